// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
//   Shared types and constants for the MM:SS stopwatch / countdown timer.
//   - state_t    : control FSM states
//   - bcd_t      : one BCD digit
//   - count_t    : the four-digit MM:SS count {m10, m1, s10, s1}
//   - DIGIT_MAX / S10_MAX : per-digit roll-over limits
//   - SSEG_*     : active-low 7-segment codes, bit order {g,f,e,d,c,b,a}
//   - count_clamp / count_inc / count_dec : BCD helpers used by the top
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t m10;
        bcd_t m1;
        bcd_t s10;
        bcd_t s1;
    } count_t;

    localparam bcd_t DIGIT_MAX = 4'd9;
    localparam bcd_t S10_MAX   = 4'd5;

    localparam logic [6:0] SSEG_0     = 7'b1000000;
    localparam logic [6:0] SSEG_1     = 7'b1111001;
    localparam logic [6:0] SSEG_2     = 7'b0100100;
    localparam logic [6:0] SSEG_3     = 7'b0110000;
    localparam logic [6:0] SSEG_4     = 7'b0011001;
    localparam logic [6:0] SSEG_5     = 7'b0010010;
    localparam logic [6:0] SSEG_6     = 7'b0000010;
    localparam logic [6:0] SSEG_7     = 7'b1111000;
    localparam logic [6:0] SSEG_8     = 7'b0000000;
    localparam logic [6:0] SSEG_9     = 7'b0010000;
    localparam logic [6:0] SSEG_BLANK = 7'b1111111;

    function automatic bcd_t clamp_digit(input bcd_t d, input bcd_t lim);
        return (d > lim) ? lim : d;
    endfunction

    // Switch values are not guaranteed to be legal BCD; saturate each digit.
    function automatic count_t count_clamp(input count_t c);
        count_t r;
        r.m10 = clamp_digit(c.m10, DIGIT_MAX);
        r.m1  = clamp_digit(c.m1,  DIGIT_MAX);
        r.s10 = clamp_digit(c.s10, S10_MAX);
        r.s1  = clamp_digit(c.s1,  DIGIT_MAX);
        return r;
    endfunction

    // One-second increment with ripple carry; 99:59 wraps to 00:00.
    function automatic count_t count_inc(input count_t c);
        count_t r;
        r = c;
        if (c.s1 != DIGIT_MAX) begin
            r.s1 = c.s1 + 4'd1;
        end else begin
            r.s1 = '0;
            if (c.s10 != S10_MAX) begin
                r.s10 = c.s10 + 4'd1;
            end else begin
                r.s10 = '0;
                if (c.m1 != DIGIT_MAX) begin
                    r.m1 = c.m1 + 4'd1;
                end else begin
                    r.m1  = '0;
                    r.m10 = (c.m10 != DIGIT_MAX) ? c.m10 + 4'd1 : '0;
                end
            end
        end
        return r;
    endfunction

    // One-second decrement with ripple borrow; mirror image of count_inc.
    function automatic count_t count_dec(input count_t c);
        count_t r;
        r = c;
        if (c.s1 != '0) begin
            r.s1 = c.s1 - 4'd1;
        end else begin
            r.s1 = DIGIT_MAX;
            if (c.s10 != '0) begin
                r.s10 = c.s10 - 4'd1;
            end else begin
                r.s10 = S10_MAX;
                if (c.m1 != '0) begin
                    r.m1 = c.m1 - 4'd1;
                end else begin
                    r.m1  = DIGIT_MAX;
                    r.m10 = (c.m10 != '0) ? c.m10 - 4'd1 : DIGIT_MAX;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_to_sseg.sv
// -----------------------------------------------------------------------------
// bcd_to_sseg
//   Combinational BCD digit to active-low 7-segment decoder.
//   Ports:
//     bcd  in  4  BCD digit (codes above 9 blank the display)
//     seg  out 7  active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module bcd_to_sseg
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SSEG_0;
            4'd1:    seg = SSEG_1;
            4'd2:    seg = SSEG_2;
            4'd3:    seg = SSEG_3;
            4'd4:    seg = SSEG_4;
            4'd5:    seg = SSEG_5;
            4'd6:    seg = SSEG_6;
            4'd7:    seg = SSEG_7;
            4'd8:    seg = SSEG_8;
            4'd9:    seg = SSEG_9;
            default: seg = SSEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stopwatch_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_counter
//   MM:SS BCD stopwatch with an optional countdown-timer mode.
//   Optional feature macro: STOPWATCH_TIMER_DOWN_EN
//     defined   : mode=1 counts down; reaching 00:00 enters DONE
//     undefined : mode is ignored, always counts up, done is tied 0
//   Parameters:
//     DIV          clk cycles per one-second count step (>= 2)
//   Ports:
//     clk          in   1   system clock, rising edge
//     rst_n        in   1   asynchronous active-low reset
//     start_stop   in   1   pulse: toggle run/pause (start from idle)
//     clear        in   1   pulse: back to 00:00 / idle
//     load         in   1   pulse: preset count from load_bcd (not in RUN)
//     load_bcd     in   16  {M10,M1,S10,S1} preset digits
//     mode         in   1   0 = up, 1 = down (sampled on start from idle)
//     seg0..seg3   out  7   registered active-low codes for S1,S10,M1,M10
//     running      out  1   registered, high while in RUN
//     done         out  1   registered, high while in DONE
// -----------------------------------------------------------------------------
module stopwatch_counter #(
    parameter int DIV = 100000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        load,
    input  logic [15:0] load_bcd,
    input  logic        mode,
    output logic [6:0]  seg0,
    output logic [6:0]  seg1,
    output logic [6:0]  seg2,
    output logic [6:0]  seg3,
    output logic        running,
    output logic        done
);

    import stopwatch_pkg::*;

    localparam int              PW         = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);

    state_t          state, state_nx;
    count_t          count, count_nx, step_val;
    logic [PW-1:0]   presc, presc_nx;
    logic [6:0]      sseg_s1, sseg_s10, sseg_m1, sseg_m10;

`ifdef STOPWATCH_TIMER_DOWN_EN
    logic            mode_q, mode_nx;
    assign step_val = mode_q ? count_dec(count) : count_inc(count);
`else
    logic            unused_mode;
    assign unused_mode = mode;
    assign step_val    = count_inc(count);
`endif

    // Next-state logic. Command priority: clear, then load, then start_stop.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path leaves a variable unassigned and infers a latch.
        state_nx = state;
        count_nx = count;
        presc_nx = presc;
`ifdef STOPWATCH_TIMER_DOWN_EN
        mode_nx  = mode_q;
`endif
        if (clear) begin
            state_nx = ST_IDLE;
            count_nx = '0;
            presc_nx = '0;
        end else if (load && (state != ST_RUN)) begin
            state_nx = ST_IDLE;
            count_nx = count_clamp(count_t'(load_bcd));
            presc_nx = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_stop) begin
                        presc_nx = '0;
                        state_nx = ST_RUN;
`ifdef STOPWATCH_TIMER_DOWN_EN
                        mode_nx  = mode;
                        // A countdown from 00:00 has already expired.
                        if (mode && (count == '0)) state_nx = ST_DONE;
`endif
                    end
                end
                ST_RUN: begin
                    // The prescaler advances on every RUN cycle, including the
                    // one on which a pause is requested.
                    if (presc == PRESC_LAST) begin
                        presc_nx = '0;
                        count_nx = step_val;
                    end else begin
                        presc_nx = presc + PW'(1);
                    end
                    if (start_stop) state_nx = ST_PAUSE;
`ifdef STOPWATCH_TIMER_DOWN_EN
                    // Expiry outranks a coincident pause request.
                    if (mode_q && (presc == PRESC_LAST) && (step_val == '0))
                        state_nx = ST_DONE;
`endif
                end
                ST_PAUSE: begin
                    if (start_stop) state_nx = ST_RUN;
                end
                default: ;  // DONE: only clear or load leave it
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the state
    // register rather than trailing it by a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            count   <= '0;
            presc   <= '0;
            running <= 1'b0;
`ifdef STOPWATCH_TIMER_DOWN_EN
            mode_q  <= 1'b0;
            done    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments for all registered state so every
            // flop samples the pre-edge values regardless of statement order.
            state   <= state_nx;
            count   <= count_nx;
            presc   <= presc_nx;
            running <= (state_nx == ST_RUN);
`ifdef STOPWATCH_TIMER_DOWN_EN
            mode_q  <= mode_nx;
            done    <= (state_nx == ST_DONE);
`endif
        end
    end

`ifndef STOPWATCH_TIMER_DOWN_EN
    assign done = 1'b0;
`endif

    bcd_to_sseg u_sseg_s1  (.bcd(count.s1),  .seg(sseg_s1));
    bcd_to_sseg u_sseg_s10 (.bcd(count.s10), .seg(sseg_s10));
    bcd_to_sseg u_sseg_m1  (.bcd(count.m1),  .seg(sseg_m1));
    bcd_to_sseg u_sseg_m10 (.bcd(count.m10), .seg(sseg_m10));

    // Display registers trail the count register by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg0 <= SSEG_0;
            seg1 <= SSEG_0;
            seg2 <= SSEG_0;
            seg3 <= SSEG_0;
        end else begin
            seg0 <= sseg_s1;
            seg1 <= sseg_s10;
            seg2 <= sseg_m1;
            seg3 <= sseg_m10;
        end
    end

endmodule

// File: tb/tb_stopwatch_counter.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_counter
//   Directed self-checking bench for stopwatch_counter with DIV = 4.
//   The count is observed through the registered segment outputs, which
//   trail the internal count by one clock.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stopwatch_counter;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_stop = 1'b0;
    logic        clear      = 1'b0;
    logic        load       = 1'b0;
    logic [15:0] load_bcd   = '0;
    logic        mode       = 1'b0;
    logic [6:0]  seg0, seg1, seg2, seg3;
    logic        running, done;

    int checks   = 0;
    int failures = 0;

    stopwatch_counter #(.DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_stop (start_stop),
        .clear      (clear),
        .load       (load),
        .load_bcd   (load_bcd),
        .mode       (mode),
        .seg0       (seg0),
        .seg1       (seg1),
        .seg2       (seg2),
        .seg3       (seg3),
        .running    (running),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Reference 7-segment table, active low {g..a}.
    function automatic logic [6:0] sseg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_disp(input string tag, input int m10, input int m1, input int s10, input int s1);
        check(tag, {seg3, seg2, seg1, seg0}, {sseg(m10), sseg(m1), sseg(s10), sseg(s1)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start();
        start_stop = 1'b1;
        tick();
        start_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic pulse_load(input logic [15:0] v);
        load_bcd = v;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset ----------------
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_disp("reset_disp", 0, 0, 0, 0);
        check("reset_running", 28'(running), 28'd0);
        check("reset_done", 28'(done), 28'd0);
        tick_n(2);
        rst_n = 1'b1;
        tick();

        // ---------------- up count, first-step timing ----------------
        pulse_start();                          // E0
        check("up_running", 28'(running), 28'd1);
        tick_n(3);                              // E3
        check_disp("up_e3", 0, 0, 0, 0);
        tick();                                 // E4: count 00:01, display lags
        check("up_e4_seg0_lag", 28'(seg0), 28'(sseg(0)));
        tick();                                 // E5
        check("up_e5_seg0", 28'(seg0), 28'(7'b1111001));

        // ---------------- clear beats load ----------------
        clear = 1'b1;
        pulse_load(16'h1234);
        clear = 1'b0;
        check("clr_ld_running", 28'(running), 28'd0);
        tick();
        check_disp("clr_ld_disp", 0, 0, 0, 0);

        // ---------------- load clamp ----------------
        pulse_load(16'hAF7C);
        tick();
        check_disp("clamp_disp", 9, 9, 5, 9);

        // ---------------- 99:59 wraps to 00:00 in RUN ----------------
        pulse_start();
        tick_n(3);
        check_disp("wrap_e3", 9, 9, 5, 9);
        tick();
        check("wrap_running", 28'(running), 28'd1);
        tick();
        check_disp("wrap_disp", 0, 0, 0, 0);

        // ---------------- 00:59 -> 01:00, load ignored in RUN ----------------
        pulse_clear();
        pulse_load(16'h0059);
        pulse_start();                          // E0
        pulse_load(16'h1111);                   // E1, ignored
        tick_n(3);                              // E4 step
        tick();
        check_disp("carry_disp", 0, 1, 0, 0);
        check("carry_running", 28'(running), 28'd1);

        // ---------------- pause / resume ----------------
        pulse_clear();
        pulse_start();                          // E0
        tick();                                 // E1
        pulse_start();                          // E2: pause
        check("pause_running", 28'(running), 28'd0);
        tick_n(10);
        check_disp("pause_hold", 0, 0, 0, 0);
        pulse_start();                          // R: resume
        check("resume_running", 28'(running), 28'd1);
        tick_n(2);                              // R+2: step
        check_disp("resume_r2", 0, 0, 0, 0);
        tick();
        check_disp("resume_r3", 0, 0, 0, 1);

`ifdef STOPWATCH_TIMER_DOWN_EN
        // ---------------- countdown to DONE ----------------
        pulse_clear();
        pulse_load(16'h0002);
        mode = 1'b1;
        pulse_start();                          // E0, mode latched
        mode = 1'b0;                            // ignored while running
        tick_n(4);                              // E4 -> 00:01
        check("down_e4_done", 28'(done), 28'd0);
        tick();
        check_disp("down_e5", 0, 0, 0, 1);
        tick_n(3);                              // E8 -> 00:00, DONE
        check("down_done", 28'(done), 28'd1);
        check("down_running", 28'(running), 28'd0);
        tick();
        check_disp("down_disp", 0, 0, 0, 0);
        pulse_start();
        check("done_ignore_ss", 28'(done), 28'd1);
        tick();
        check_disp("done_hold", 0, 0, 0, 0);

        // ---------------- start down from 00:00 ----------------
        pulse_clear();
        check("clr_done", 28'(done), 28'd0);
        mode = 1'b1;
        pulse_start();
        mode = 1'b0;
        check("zero_start_done", 28'(done), 28'd1);
        check("zero_start_run", 28'(running), 28'd0);
`else
        // ---------------- mode ignored without the timer option ----------------
        pulse_clear();
        pulse_load(16'h0002);
        mode = 1'b1;
        pulse_start();
        tick_n(4);
        tick();
        check_disp("noopt_up_disp", 0, 0, 0, 3);
        check("noopt_done", 28'(done), 28'd0);
        mode = 1'b0;
`endif

        // ---------------- async reset mid-run ----------------
        pulse_clear();
        pulse_load(16'h0123);
        pulse_start();                          // E0
        tick_n(2);                              // E2, prescaler part way
        #3 rst_n = 1'b0;                        // between clock edges
        #1;
        check_disp("async_disp", 0, 0, 0, 0);
        check("async_running", 28'(running), 28'd0);
        check("async_done", 28'(done), 28'd0);
        #2 rst_n = 1'b1;
        tick();
        check("post_rst_running", 28'(running), 28'd0);
        pulse_start();                          // fresh E0
        tick_n(4);
        check_disp("post_rst_e4", 0, 0, 0, 0);
        tick();
        check_disp("post_rst_e5", 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
